// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// imem_ctrl_pkg : shared fetch-side constants (PC select, NOP, IMEM FSM). Rev 1.0
// ============================================================================
package imem_ctrl_pkg;

  localparam int PC_SEL_WIDTH = 2;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR   = 2'd2;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_TRAP   = 2'd3;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMEM_ST_WIDTH = 1;
  typedef enum logic [IMEM_ST_WIDTH-1:0] {
    IMEM_IDLE = 1'b0,
    IMEM_WAIT = 1'b1
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_ctrl.sv
`default_nettype none
// ============================================================================
// imem_ctrl : single-entry fetch buffer bridging fetch to a req/ack memory. Rev 1.0
// ============================================================================
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_imem,
  output logic [XLEN-1:0] instr_imem,
  output logic            imem_busy,
  input  logic            inv,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int TAG_W = XLEN - 2;

  imem_state_t       r_state,     w_state_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic [XLEN-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic              r_buf_valid, w_buf_valid_nxt;
  logic [TAG_W-1:0]  r_buf_tag,   w_buf_tag_nxt;
  logic [XLEN-1:0]   r_buf_data,  w_buf_data_nxt;
  logic [TAG_W-1:0]  r_req_tag,   w_req_tag_nxt;
  logic              r_drop,      w_drop_nxt;

  logic [TAG_W-1:0]  w_pc_tag;
  logic              w_hit;
  logic              w_unused_pc_lsb;

  assign w_pc_tag        = pc_imem[XLEN-1:2];
  assign w_unused_pc_lsb = ^pc_imem[1:0];

  // Output path depends only on registers and the PC, never on the memory side.
  assign w_hit      = r_buf_valid && (r_buf_tag == w_pc_tag) && (r_state == IMEM_IDLE);
  assign imem_busy  = ~w_hit;
  assign instr_imem = w_hit ? r_buf_data : XLEN'(NOP_INSTR);
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_tag_nxt   = r_buf_tag;
    w_buf_data_nxt  = r_buf_data;
    w_req_tag_nxt   = r_req_tag;
    w_drop_nxt      = r_drop;

    case (r_state)
      IMEM_IDLE: begin
        if (!w_hit) begin
          w_req_tag_nxt  = w_pc_tag;
          w_mem_addr_nxt = {w_pc_tag, 2'b00};
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = IMEM_WAIT;
        end
      end
      IMEM_WAIT: begin
        if (r_mem_req && mem_ack) begin
          // A redirected request still fills under its own tag; a dropped one stays invalid.
          w_buf_data_nxt  = mem_rdata;
          w_buf_tag_nxt   = r_req_tag;
          w_buf_valid_nxt = ~r_drop;
          w_drop_nxt      = 1'b0;
          w_mem_req_nxt   = 1'b0;
          w_state_nxt     = IMEM_IDLE;
        end else if (inv) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IMEM_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase

    if (inv) begin
      w_buf_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IMEM_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= XLEN'(NOP_INSTR);
      r_req_tag   <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_tag   <= w_buf_tag_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_req_tag   <= w_req_tag_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_imem_ctrl : randomized scoreboard bench for imem_ctrl. Rev 1.0
// ============================================================================
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_imem = '0;
  logic [31:0] instr_imem;
  logic        imem_busy;
  logic        inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  imem_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_imem(pc_imem), .instr_imem(instr_imem),
    .imem_busy(imem_busy), .inv(inv), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Memory contents: word 0 holds addi x1,x0,0; others a fixed hash of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp, input int c);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endfunction

  // Monitor: every presented cycle pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("busy",     {31'b0, imem_busy}, {31'b0, e.busy}, e.cyc);
      check("instr",    instr_imem,         e.instr,         e.cyc);
      check("mem_req",  {31'b0, mem_req},   {31'b0, e.req},  e.cyc);
      check("mem_addr", mem_addr,           e.addr,          e.cyc);
    end
  end

  // Reference model: is a fetch outstanding, what word the buffer holds.
  bit          m_known = 0, m_wait = 0, m_bvalid = 0, m_drop = 0;
  logic [29:0] m_btag = '0, m_ptag = '0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0, m_lat = 0;
  int          lat_override = -1;

  task automatic step(input logic [31:0] pc, input logic iv, input logic rs);
    exp_t e;
    logic hit;
    logic ack_v;
    logic [31:0] rd_v;
    hit = 1'b0;
    @(posedge clk); #1;
    cyc++;
    ack_v = 1'b0;
    rd_v  = $urandom;
    if (m_known && m_wait && m_cnt >= m_lat) begin
      ack_v = 1'b1;
      rd_v  = mem_fn(mem_addr);
    end else if (m_known && !m_wait && $urandom_range(0, 7) == 0) begin
      ack_v = 1'b1;
    end
    pc_imem = pc; inv = iv; rst = rs; mem_ack = ack_v; mem_rdata = rd_v;

    if (m_known) begin
      hit     = !m_wait && m_bvalid && (m_btag == pc[31:2]);
      e.busy  = !hit;
      e.instr = hit ? mem_fn({m_btag, 2'b00}) : NOP_INSTR;
      e.req   = m_wait;
      e.addr  = m_addr;
      e.cyc   = cyc;
      sb_q.push_back(e);
    end

    if (rs) begin
      m_known = 1; m_wait = 0; m_bvalid = 0; m_drop = 0;
      m_btag = '0; m_ptag = '0; m_addr = '0;
    end else if (m_known) begin
      if (!m_wait) begin
        if (!hit) begin
          m_wait = 1; m_ptag = pc[31:2]; m_addr = {pc[31:2], 2'b00}; m_cnt = 0;
          m_lat = (lat_override >= 0) ? lat_override :
                  ($urandom_range(0, 9) < 7 ? $urandom_range(0, 2) : $urandom_range(3, 9));
        end
        if (iv) m_bvalid = 0;
      end else if (ack_v) begin
        m_bvalid = !(m_drop || iv);
        m_btag = m_ptag; m_wait = 0; m_drop = 0;
      end else begin
        m_cnt++;
        if (iv) begin m_drop = 1; m_bvalid = 0; end
      end
    end
  endtask

  task automatic hold(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) step(pc, 1'b0, 1'b0);
  endtask

  logic [31:0] pcs [10] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h13,
                            32'h24, 32'h40, 32'h100, 32'h104, 32'hFFFF_FFFC};

  initial begin
    logic [31:0] pc;
    step(32'h0, 1'b0, 1'b1);
    lat_override = 0;
    hold(32'h0, 4);
    hold(32'h10, 8);
    lat_override = 7;
    hold(32'h24, 12);
    lat_override = 3;
    hold(32'h40, 2);
    lat_override = 1;
    hold(32'h100, 10);
    lat_override = 4;
    hold(32'h8, 2);
    step(32'h8, 1'b1, 1'b0);
    hold(32'h8, 12);
    lat_override = -1;
    hold(32'h13, 8);
    hold(32'h10, 4);

    pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 4) pc = pcs[$urandom_range(0, 9)];
      step(pc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
    end
    step(pc, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_ctrl.md
# imem_ctrl

Instruction-memory controller sitting directly upstream of the fetch stage. Accepts the fetch stage's word address on `pc_imem`, returns the instruction on `instr_imem`, and raises `imem_busy` while the word is not yet available. It bridges fetch to a variable-latency, word-wide memory over a req/ack handshake. A single-entry fetch buffer lets a stalled fetch stage re-read the same PC without issuing another memory request.

## Interface
- `XLEN`, 32: address and data width.
- `NOP_INSTR`, 32'h0000_0013: instruction driven on `instr_imem` while busy (`addi x0,x0,0`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `pc_imem` input XLEN: fetch PC; bits [1:0] are ignored.
- `instr_imem` output XLEN: instruction for `pc_imem`; `NOP_INSTR` when `imem_busy` is 1.
- `imem_busy` output 1: instruction not available this cycle; the hazard unit ORs this into `stall_if`.
- `inv` input 1: invalidate the fetch buffer (fence.i).
- `mem_req` output 1: registered memory request.
- `mem_addr` output XLEN: registered word address, {pc[XLEN-1:2],2'b00}.
- `mem_ack` input 1: read data valid; meaningful only while `mem_req`=1.
- `mem_rdata` input XLEN: read data, sampled when `mem_ack`=1.

## Operation
- **State:**
  - FSM states IDLE and WAIT.
  - Buffer registers `buf_valid`, `buf_tag`[XLEN-1:2], `buf_data`.
  - `req_tag`[XLEN-1:2].
- **Hit:** `buf_valid` && `buf_tag`==`pc_imem`[XLEN-1:2] && state==IDLE.
  - `instr_imem`=`buf_data`, `imem_busy`=0.
  - All combinational from registers and `pc_imem`.
- **IDLE, miss:**
  - `imem_busy`=1 and `instr_imem`=`NOP_INSTR` in the same cycle (combinational).
  - Next edge: `req_tag`<=`pc_imem`[XLEN-1:2], `mem_addr`<=word address, `mem_req`<=1, state<=WAIT.
- **WAIT:**
  - `imem_busy`=1 unconditionally.
  - `mem_req` and `mem_addr` are held stable until ack.
  - On an edge with `mem_ack`=1:
    - `buf_data`<=`mem_rdata`, `buf_tag`<=`req_tag`, `buf_valid`<=1.
    - `mem_req`<=0, state<=IDLE.
- **Redirect mid-request** (`pc_imem` changes during WAIT, e.g. branch or flush):
  - The outstanding request is never cancelled; it completes and fills the buffer with `req_tag`.
  - The next IDLE cycle then misses on the new PC and issues a fresh request.
- **`inv`:**
  - `buf_valid`<=0 at the edge.
  - `inv` in WAIT sets a sticky `drop` flag. The returning ack still ends the request (`mem_req`<=0, state<=IDLE) but leaves `buf_valid`=0.
  - `drop` clears on that ack.
  - `inv` coincident with ack in WAIT also results in `buf_valid`=0.
  - `inv` during an IDLE hit forces busy from the next cycle.
- **Stray ack:** `mem_ack` while `mem_req`=0 is ignored.
- **Reset values:** state=IDLE, `mem_req`=0, `mem_addr`=0, `buf_valid`=0, `buf_tag`=0, `buf_data`=`NOP_INSTR`, `req_tag`=0, `drop`=0.
  - Consequently `imem_busy`=1 in the first cycle after reset (miss).
- **Reset mid-WAIT:** `mem_req` drops at the reset edge and the request is abandoned; the memory side must tolerate this.

## Timing
- Hit: zero latency; `instr_imem` is valid in the same cycle `pc_imem` is presented.
- Miss timeline:
  - Miss detected in cycle N.
  - `mem_req`=1 from N+1.
  - Earliest ack in N+1.
  - Hit in N+2.
  - Minimum miss penalty is 2 busy cycles; with ack at cycle M, `imem_busy` is 1 for cycles N..M.
- Back-to-back sequential fetch: every new word costs at least 2 busy cycles. There is no prefetch of PC+4.
- No combinational path from `mem_ack`/`mem_rdata` to `instr_imem` or `imem_busy`; data is always delivered from `buf_data`.

## Structure
- `NOP_INSTR` and the IMEM FSM state encodings (IMEM_IDLE, IMEM_WAIT, width `IMEM_ST_WIDTH`) go in the shared constants header alongside the existing PC_SEL constants.
- No sub-module: the buffer and FSM are one small always_ff plus one always_comb.

## Test plan
- **Reset then fetch:**
  - Stimulus: `rst` 1 cycle, `pc_imem`=0, memory acks 1 cycle after req with 32'h0000_0093.
  - Required: `imem_busy`=1 for 2 cycles, `mem_addr`=0, then `instr_imem`=32'h0000_0093 with busy=0.
- **Hit while stalled:**
  - Stimulus: hold `pc_imem`=0x10 for 5 cycles after its fill.
  - Required: exactly one `mem_req` assertion, `instr_imem` stable, busy=0 for all 5 cycles.
- **Variable latency:**
  - Stimulus: ack delayed 7 cycles on `pc_imem`=0x24.
  - Required: `mem_req`/`mem_addr`=0x24 held for all 7 cycles, busy=1 for 8 cycles, `instr_imem`=NOP throughout.
- **Redirect mid-WAIT:**
  - Stimulus: `pc_imem` changes 0x40→0x100 while waiting.
  - Required: the 0x40 request completes; the next request is `mem_addr`=0x100; data returned for 0x100 is correct; busy stays 1 until that fill.
- **Invalidate during WAIT:**
  - Stimulus: `inv` pulse during a WAIT on 0x8.
  - Required: after ack, `buf_valid`=0; the same PC issues a second request.
- **Misaligned PC and stray ack:**
  - Stimulus: `pc_imem`=0x13; also a stray `mem_ack` in IDLE.
  - Required: `mem_addr`=0x10, and a hit on 0x10 data after fill; the stray ack causes no state or buffer change.
